// File: rtl/credit_display_controller.sv
// -----------------------------------------------------------------------------
// credit_display_controller
//
// Purpose:
//   Drives the cabinet's multiplexed 7-segment credit display. Each load strobe
//   takes a binary credit count. The count is saturated to the largest value
//   the display can show. A sequential double-dabble engine then converts it to
//   BCD, one bit per clock. The result is latched into a display register. The
//   digits of that register are time-multiplexed onto one shared, active-low
//   segment bus.
//
// Ports:
//   clk                  in   system clock (VGA pixel clock domain)
//   reset                in   asynchronous, active-high reset
//   win_credits          in   win amount for the last spin
//   is_win               in   single-cycle load strobe for win_credits
//   total_credits        in   player credit balance
//   is_total             in   single-cycle load strobe for total_credits
//                             (wins over is_win when both are high)
//   seven_segment_output out  segments {g,f,e,d,c,b,a}, active-low, registered
//   digit_en             out  digit enables, active-low one-hot, registered
//   busy                 out  conversion in progress
//   showing_win          out  display register currently holds a win amount
//
// Build option:
//   SEVSEG_WIN_BLINK_EN  when defined, a win amount blinks with a half-period
//                        of BLINK_DIV clocks. When undefined, wins are shown
//                        steadily and BLINK_DIV is only range-checked.
// -----------------------------------------------------------------------------
module credit_display_controller #(
    parameter int CREDIT_W    = 14,
    parameter int NDIGITS     = 4,
    parameter int REFRESH_DIV = 4096,
    parameter int BLINK_DIV   = 4194304
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CREDIT_W-1:0] win_credits,
    input  logic                is_win,
    input  logic [CREDIT_W-1:0] total_credits,
    input  logic                is_total,
    output logic [6:0]          seven_segment_output,
    output logic [NDIGITS-1:0]  digit_en,
    output logic                busy,
    output logic                showing_win
);

    // Largest decimal value the display can hold, e.g. 9999 for four digits.
    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    localparam longint MAX_VAL = pow10(NDIGITS) - 1;
    localparam int     BCD_W   = 4 * NDIGITS;
    localparam int     CNT_W   = $clog2(CREDIT_W + 1);
    localparam int     REF_W   = $clog2(REFRESH_DIV);
    localparam int     IDX_W   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    // Conversion FSM encoding
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    // Refuse to elaborate with settings the counters cannot represent.
    if (CREDIT_W < 2 || NDIGITS < 1 || REFRESH_DIV < 2 || BLINK_DIV < 2) begin : gen_param_check
        $error("credit_display_controller: unsupported parameter values");
    end

    // Values beyond what the display can show are clamped before conversion,
    // so the BCD accumulator never has to hold a carry out of the top digit.
    function automatic logic [CREDIT_W-1:0] saturate(input logic [CREDIT_W-1:0] v);
        if (longint'(v) > MAX_VAL) begin
            return CREDIT_W'(MAX_VAL);
        end
        return v;
    endfunction

    // Standard active-low 0-9 patterns, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decodeDigit(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    logic [1:0]          state_q,     state_d;
    logic [CREDIT_W-1:0] bin_q,       bin_d;
    logic [BCD_W-1:0]    bcd_q,       bcd_d;
    logic [CNT_W-1:0]    bitCnt_q,    bitCnt_d;
    logic                tag_q,       tag_d;
    logic                pendValid_q, pendValid_d;
    logic [CREDIT_W-1:0] pendVal_q,   pendVal_d;
    logic                pendWin_q,   pendWin_d;
    logic [BCD_W-1:0]    disp_q,      disp_d;
    logic                showWin_q,   showWin_d;
    logic [REF_W-1:0]    refCnt_q,    refCnt_d;
    logic [IDX_W-1:0]    idx_q,       idx_d;
    logic [6:0]          seg_q,       seg_d;
    logic [NDIGITS-1:0]  digEn_q,     digEn_d;

    logic                newValid;
    logic                newWin;
    logic [CREDIT_W-1:0] newVal;
    logic                startPend;
    logic                startNew;
    logic [BCD_W-1:0]    adjusted;
    logic [NDIGITS-1:0]  blank;
    logic                blinkOff;

    // Pick the incoming strobe. A total beats a win arriving in the same cycle.
    // The chosen value is saturated here, so a pending entry holds the final value.
    always_comb begin
        newValid = is_total | is_win;
        newWin   = is_win & ~is_total;
        newVal   = saturate(is_total ? total_credits : win_credits);
    end

    // The one-entry pending buffer. An idle FSM drains the pending entry first.
    // A strobe is captured whenever it cannot start a conversion right away:
    // either the FSM is busy, or it is idle but draining a pending entry.
    // The newest strobe always overwrites the entry.
    always_comb begin
        startPend   = (state_q == S_IDLE) && pendValid_q;
        startNew    = (state_q == S_IDLE) && !pendValid_q && newValid;
        pendValid_d = pendValid_q;
        pendVal_d   = pendVal_q;
        pendWin_d   = pendWin_q;
        if (startPend) begin
            pendValid_d = 1'b0;
        end
        if (newValid && !startNew) begin
            pendValid_d = 1'b1;
            pendVal_d   = newVal;
            pendWin_d   = newWin;
        end
    end

    // Conversion FSM. SHIFT runs one double-dabble step per clock. Each step
    // adds 3 to every nibble of 5 or more, then shifts the binary MSB into the
    // BCD accumulator. After CREDIT_W steps the accumulator holds the decimal
    // value. COMMIT is the only place the display register is written, so the
    // display keeps the previous value while a conversion runs.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        bitCnt_d  = bitCnt_q;
        tag_d     = tag_q;
        disp_d    = disp_q;
        showWin_d = showWin_q;
        adjusted  = bcd_q;
        for (int k = 0; k < NDIGITS; k++) begin
            if (adjusted[4*k +: 4] >= 4'd5) begin
                adjusted[4*k +: 4] = adjusted[4*k +: 4] + 4'd3;
            end
        end
        case (state_q)
            S_IDLE: begin
                if (startPend || startNew) begin
                    bin_d    = startPend ? pendVal_q : newVal;
                    tag_d    = startPend ? pendWin_q : newWin;
                    bcd_d    = '0;
                    bitCnt_d = '0;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bcd_d    = {adjusted[BCD_W-2:0], bin_q[CREDIT_W-1]};
                bin_d    = {bin_q[CREDIT_W-2:0], 1'b0};
                bitCnt_d = bitCnt_q + CNT_W'(1);
                if (bitCnt_q == CNT_W'(CREDIT_W - 1)) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                disp_d    = bcd_q;
                showWin_d = tag_q;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Leading-zero blanking. Walk down from the most significant digit.
    // A digit is blank while it and every digit above it are zero.
    // Digit 0 always shows, so a zero balance still reads "0".
    always_comb begin
        logic allZero;
        allZero = 1'b1;
        blank   = '0;
        for (int k = NDIGITS - 1; k >= 0; k--) begin
            allZero  = allZero & (disp_q[4*k +: 4] == 4'd0);
            blank[k] = (k != 0) ? allZero : 1'b0;
        end
    end

    // Digit scan. Each digit stays enabled for REFRESH_DIV clocks.
    // The segment and enable registers are both loaded every clock from the
    // next digit index. They therefore always switch on the same edge, which
    // avoids ghosting between neighbouring digits.
    always_comb begin
        logic [3:0] nibble;
        logic       blankSel;
        refCnt_d = refCnt_q + REF_W'(1);
        idx_d    = idx_q;
        if (refCnt_q == REF_W'(REFRESH_DIV - 1)) begin
            refCnt_d = '0;
            idx_d    = (idx_q == IDX_W'(NDIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        nibble   = 4'd0;
        blankSel = 1'b0;
        for (int k = 0; k < NDIGITS; k++) begin
            if (idx_d == IDX_W'(k)) begin
                nibble   = disp_q[4*k +: 4];
                blankSel = blank[k];
            end
        end
        seg_d   = (blankSel || blinkOff) ? 7'h7F : decodeDigit(nibble);
        digEn_d = ~(NDIGITS'(1) << idx_d);
    end

`ifdef SEVSEG_WIN_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_DIV);

    logic [BLINK_W-1:0] blinkCnt_q, blinkCnt_d;
    logic               blinkOn_q,  blinkOn_d;

    // Blink phase for win amounts. Every COMMIT restarts the phase in the on
    // state, so a new value is always visible at once. While a total is shown
    // the counter is held, so totals never blink.
    always_comb begin
        blinkCnt_d = blinkCnt_q;
        blinkOn_d  = blinkOn_q;
        if (state_q == S_COMMIT) begin
            blinkCnt_d = '0;
            blinkOn_d  = 1'b1;
        end else if (showWin_q) begin
            if (blinkCnt_q == BLINK_W'(BLINK_DIV - 1)) begin
                blinkCnt_d = '0;
                blinkOn_d  = ~blinkOn_q;
            end else begin
                blinkCnt_d = blinkCnt_q + BLINK_W'(1);
            end
        end else begin
            blinkCnt_d = '0;
            blinkOn_d  = 1'b1;
        end
    end

    // Blink phase registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blinkCnt_q <= '0;
            blinkOn_q  <= 1'b1;
        end else begin
            blinkCnt_q <= blinkCnt_d;
            blinkOn_q  <= blinkOn_d;
        end
    end

    assign blinkOff = ~blinkOn_q;
`else
    assign blinkOff = 1'b0;
`endif

    // State registers. Reset discards any running conversion and any pending
    // entry. It puts the outputs straight back to showing "0" on digit 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            bitCnt_q    <= '0;
            tag_q       <= 1'b0;
            pendValid_q <= 1'b0;
            pendVal_q   <= '0;
            pendWin_q   <= 1'b0;
            disp_q      <= '0;
            showWin_q   <= 1'b0;
            refCnt_q    <= '0;
            idx_q       <= '0;
            seg_q       <= 7'b1000000;
            digEn_q     <= ~NDIGITS'(1);
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            bitCnt_q    <= bitCnt_d;
            tag_q       <= tag_d;
            pendValid_q <= pendValid_d;
            pendVal_q   <= pendVal_d;
            pendWin_q   <= pendWin_d;
            disp_q      <= disp_d;
            showWin_q   <= showWin_d;
            refCnt_q    <= refCnt_d;
            idx_q       <= idx_d;
            seg_q       <= seg_d;
            digEn_q     <= digEn_d;
        end
    end

    assign seven_segment_output = seg_q;
    assign digit_en             = digEn_q;
    assign busy                 = (state_q != S_IDLE);
    assign showing_win          = showWin_q;

endmodule

// File: tb/tb_credit_display_controller.sv
// -----------------------------------------------------------------------------
// tb_credit_display_controller
//
// Directed bench for credit_display_controller. It uses a short refresh period
// so that a full scan takes only a few clocks. A free-running cycle counter,
// cleared by reset, predicts which digit should be enabled at each sample.
// Expected segment patterns come from the decimal value and that digit index.
// -----------------------------------------------------------------------------
module tb_credit_display_controller;

    localparam int CREDIT_W    = 14;
    localparam int NDIGITS     = 4;
    localparam int REFRESH_DIV = 4;
    localparam int BLINK_DIV   = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic [CREDIT_W-1:0] win_credits;
    logic                is_win;
    logic [CREDIT_W-1:0] total_credits;
    logic                is_total;
    logic [6:0]          seven_segment_output;
    logic [NDIGITS-1:0]  digit_en;
    logic                busy;
    logic                showing_win;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int cyc;

    credit_display_controller #(
        .CREDIT_W(CREDIT_W),
        .NDIGITS(NDIGITS),
        .REFRESH_DIV(REFRESH_DIV),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .win_credits(win_credits),
        .is_win(is_win),
        .total_credits(total_credits),
        .is_total(is_total),
        .seven_segment_output(seven_segment_output),
        .digit_en(digit_en),
        .busy(busy),
        .showing_win(showing_win)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Clocks since reset was released; selects the digit expected to be lit.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Hang guard
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] segPattern(input int d);
        case (d)
            0:       return 7'h40;
            1:       return 7'h79;
            2:       return 7'h24;
            3:       return 7'h30;
            4:       return 7'h19;
            5:       return 7'h12;
            6:       return 7'h02;
            7:       return 7'h78;
            8:       return 7'h00;
            9:       return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected pattern of digit k when the display holds 'value'
    function automatic logic [6:0] expSeg(input int value, input int k);
        if (k > 0 && value < pow10(k)) return 7'h7F;
        return segPattern((value / pow10(k)) % 10);
    endfunction

    // One comparison: counts it, and reports tag/observed/expected on failure
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one strobe cycle; called at a negedge, returns one negedge later
    task automatic applyStimulus(input logic doWin, input int winVal, input logic doTotal, input int totVal);
        win_credits   = CREDIT_W'(winVal);
        total_credits = CREDIT_W'(totVal);
        is_win        = doWin;
        is_total      = doTotal;
        @(negedge clk);
        is_win   = 1'b0;
        is_total = 1'b0;
    endtask

    // Count samples with busy high; bounded so a stuck FSM still ends the run
    task automatic waitIdle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Check the currently scanned digit against the model
    task automatic checkNow(input int value, input string tag);
        int         k;
        logic [3:0] expEn;
        k     = (cyc / REFRESH_DIV) % NDIGITS;
        expEn = ~(4'b0001 << k);
        checkOutput({tag, "_digit_en"}, {12'b0, digit_en}, {12'b0, expEn});
        checkOutput({tag, "_seg"}, {9'b0, seven_segment_output}, {9'b0, expSeg(value, k)});
    endtask

    // Walk through all digits, one refresh period apart
    task automatic checkScan(input int value, input string tag);
        @(negedge clk);
        for (int i = 0; i < NDIGITS; i++) begin
            checkNow(value, tag);
            repeat (REFRESH_DIV) @(negedge clk);
        end
    endtask

    initial begin
        int n;
        reset         = 1'b1;
        win_credits   = '0;
        total_credits = '0;
        is_win        = 1'b0;
        is_total      = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        checkOutput("rst_busy", {15'b0, busy}, 16'h0);
        checkOutput("rst_showing_win", {15'b0, showing_win}, 16'h0);
        checkOutput("rst_digit_en", {12'b0, digit_en}, 16'hE);
        checkOutput("rst_seg", {9'b0, seven_segment_output}, 16'h40);
        checkScan(0, "scan_zero");

        // Total 1234: busy for 15 cycles, then display 1234
        applyStimulus(1'b0, 0, 1'b1, 1234);
        waitIdle(n);
        checkOutput("busy_len_1234", 16'(n), 16'd15);
        checkOutput("sw_1234", {15'b0, showing_win}, 16'h0);
        checkScan(1234, "scan_1234");

        // Win 60 sets showing_win
        applyStimulus(1'b1, 60, 1'b0, 0);
        waitIdle(n);
        checkOutput("busy_len_60", 16'(n), 16'd15);
        checkOutput("sw_60", {15'b0, showing_win}, 16'h1);
`ifndef SEVSEG_WIN_BLINK_EN
        checkScan(60, "scan_60");
`endif

        // Simultaneous win 40 / total 500: total taken
        applyStimulus(1'b1, 40, 1'b1, 500);
        waitIdle(n);
        checkOutput("sw_500", {15'b0, showing_win}, 16'h0);
        checkScan(500, "scan_500");

        // Total 7, then during busy win 25 and total 300; 25 is overwritten
        applyStimulus(1'b0, 0, 1'b1, 7);
        @(negedge clk);
        applyStimulus(1'b1, 25, 1'b0, 0);
        applyStimulus(1'b0, 0, 1'b1, 300);
        waitIdle(n);
        checkOutput("busy_len_7", 16'(n), 16'd12);
        checkOutput("sw_7", {15'b0, showing_win}, 16'h0);
        checkOutput("gap_idle", {15'b0, busy}, 16'h0);
        @(negedge clk);
        checkOutput("gap_restart", {15'b0, busy}, 16'h1);
        checkNow(7, "show_7");
        waitIdle(n);
        checkOutput("busy_len_300", 16'(n), 16'd15);
        checkOutput("sw_300", {15'b0, showing_win}, 16'h0);
        checkScan(300, "scan_300");

        // Saturation
        applyStimulus(1'b0, 0, 1'b1, 16383);
        waitIdle(n);
        checkOutput("busy_len_sat", 16'(n), 16'd15);
        checkScan(9999, "scan_sat");

`ifdef SEVSEG_WIN_BLINK_EN
        // Win 50 blinks with an 8-cycle half period
        applyStimulus(1'b1, 50, 1'b0, 0);
        waitIdle(n);
        for (int m = 1; m <= 32; m++) begin
            logic [6:0] e;
            @(negedge clk);
            if (((m - 1) / BLINK_DIV) % 2 == 1) e = 7'h7F;
            else e = expSeg(50, (cyc / REFRESH_DIV) % NDIGITS);
            checkOutput("blink_seg", {9'b0, seven_segment_output}, {9'b0, e});
        end
`endif

        // Reset in the middle of a conversion
        applyStimulus(1'b1, 60, 1'b0, 0);
        waitIdle(n);
        checkOutput("sw_pre_reset", {15'b0, showing_win}, 16'h1);
        applyStimulus(1'b0, 0, 1'b1, 555);
        repeat (4) @(negedge clk);
        checkOutput("busy_mid_shift", {15'b0, busy}, 16'h1);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_busy", {15'b0, busy}, 16'h0);
        checkOutput("mid_rst_sw", {15'b0, showing_win}, 16'h0);
        checkOutput("mid_rst_digit_en", {12'b0, digit_en}, 16'hE);
        checkOutput("mid_rst_seg", {9'b0, seven_segment_output}, 16'h40);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("post_rst_busy", {15'b0, busy}, 16'h0);
        checkOutput("post_rst_sw", {15'b0, showing_win}, 16'h0);
        checkScan(0, "scan_post_rst");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
